// File: rtl/blackjack_turn_controller_pkg.sv
// Shared types for the BlackJack turn controller: command/result codes,
// sequencer states and hand/card widths, plus the card-value clamp.
package blackjack_turn_controller_pkg;

    localparam int CARD_W = 4;
    localparam int SUM_W  = 5;

    typedef enum logic [1:0] {
        COMMAND_NONE  = 2'd0,
        COMMAND_HIT   = 2'd1,
        COMMAND_STAND = 2'd2
    } game_command_e;

    typedef enum logic [1:0] {
        RESULT_NONE       = 2'd0,
        RESULT_PLAYER_WIN = 2'd1,
        RESULT_DEALER_WIN = 2'd2,
        RESULT_PUSH       = 2'd3
    } game_result_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEAL,
        ST_PLAYER_WAIT,
        ST_PLAYER_DRAW,
        ST_DEALER_EVAL,
        ST_DEALER_DRAW,
        ST_RESOLVE,
        ST_DONE
    } state_e;

    // Out-of-range card codes (0, 11..15) count as a ten-value card.
    function automatic logic [CARD_W-1:0] clamp_card(input logic [CARD_W-1:0] v);
        return ((v == '0) || (v > CARD_W'(10))) ? CARD_W'(10) : v;
    endfunction

endpackage

// File: rtl/blackjack_turn_controller_hand_accumulator.sv
// One hand's running total: saturating hard sum, ace flag, and the derived
// best total (ace counted as 11 when it does not bust) and bust flag.
module blackjack_turn_controller_hand_accumulator
    import blackjack_turn_controller_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_clear,
    input  logic              i_add,
    input  logic [CARD_W-1:0] i_value,
    output logic [SUM_W-1:0]  o_hard,
    output logic              o_has_ace,
    output logic [SUM_W-1:0]  o_best,
    output logic              o_bust
);

    logic [SUM_W-1:0]  hard_q, hard_d;
    logic              ace_q, ace_d;
    logic [CARD_W-1:0] card;
    logic [SUM_W:0]    sum_wide;

    // Next hand state: clear wins over add; hard sum saturates at the 5-bit max.
    always_comb begin
        hard_d   = hard_q;
        ace_d    = ace_q;
        card     = clamp_card(i_value);
        sum_wide = {1'b0, hard_q} + {{(SUM_W+1-CARD_W){1'b0}}, card};
        if (i_clear) begin
            hard_d = '0;
            ace_d  = 1'b0;
        end else if (i_add) begin
            hard_d = sum_wide[SUM_W] ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
            ace_d  = ace_q | (card == CARD_W'(1));
        end
    end

    // Hand registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hard_q <= '0;
            ace_q  <= 1'b0;
        end else begin
            hard_q <= hard_d;
            ace_q  <= ace_d;
        end
    end

    assign o_hard    = hard_q;
    assign o_has_ace = ace_q;
    assign o_best    = (ace_q && (hard_q <= SUM_W'(11))) ? hard_q + SUM_W'(10) : hard_q;
    assign o_bust    = hard_q > SUM_W'(21);

endmodule

// File: rtl/blackjack_turn_controller.sv
// BlackJack game sequencer: deal, player turn, dealer turn, resolve, hold.
// Cards arrive over a registered req / valid handshake; each accepted card
// is followed by one cycle with the request low, during which the freshly
// updated hand totals drive the next decision.
// Optional build macro DEALER_HIT_SOFT17_EN: dealer also draws on soft 17.
module blackjack_turn_controller
    import blackjack_turn_controller_pkg::*;
#(
    parameter int DEALER_STAND = 17,
    parameter int INIT_CARDS   = 4
)(
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_dealButtonPushed,
    input  logic              i_ready,
    input  logic [1:0]        i_command,
    input  logic              i_cardValid,
    input  logic [CARD_W-1:0] i_cardValue,
    output logic              o_cardReq,
    output logic              o_cardToDealer,
    output logic              o_turnIndicator,
    output logic [SUM_W-1:0]  o_playerSum,
    output logic [SUM_W-1:0]  o_dealerSum,
    output logic [1:0]        o_result,
    output logic              o_busy
);

    localparam int CNT_W = $clog2(INIT_CARDS + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic [1:0]       result_q, result_d;

    logic             accept, hand_clear, p_add, d_add;
    logic [SUM_W-1:0] p_hard, p_best, d_hard, d_best;
    logic             p_ace, p_bust, d_ace, d_bust;
    logic             dealer_soft_hit;
    logic             unused_hand_bits;

    assign accept = req_q & i_cardValid;

    // Route an accepted card: during the deal even slots go to the player.
    assign p_add = accept && (((state_q == ST_DEAL) && !cnt_q[0]) || (state_q == ST_PLAYER_DRAW));
    assign d_add = accept && (((state_q == ST_DEAL) &&  cnt_q[0]) || (state_q == ST_DEALER_DRAW));

    blackjack_turn_controller_hand_accumulator u_player (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (hand_clear),
        .i_add     (p_add),
        .i_value   (i_cardValue),
        .o_hard    (p_hard),
        .o_has_ace (p_ace),
        .o_best    (p_best),
        .o_bust    (p_bust)
    );

    blackjack_turn_controller_hand_accumulator u_dealer (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (hand_clear),
        .i_add     (d_add),
        .i_value   (i_cardValue),
        .o_hard    (d_hard),
        .o_has_ace (d_ace),
        .o_best    (d_best),
        .o_bust    (d_bust)
    );

`ifdef DEALER_HIT_SOFT17_EN
    assign dealer_soft_hit = (d_best == SUM_W'(DEALER_STAND)) && d_ace && (d_hard <= SUM_W'(11));
`else
    assign dealer_soft_hit = 1'b0;
`endif

    assign unused_hand_bits = ^{p_hard, p_ace, d_hard, d_ace};

    // Next-state, card-request and result logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        result_d   = result_q;
        hand_clear = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_dealButtonPushed) begin
                    hand_clear = 1'b1;
                    result_d   = RESULT_NONE;
                    cnt_d      = '0;
                    req_d      = 1'b1;
                    state_d    = ST_DEAL;
                end
            end
            ST_DEAL: begin
                if (accept) begin
                    req_d = 1'b0;
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (!req_q) begin
                    if (cnt_q == CNT_W'(INIT_CARDS))
                        state_d = (p_best == SUM_W'(21)) ? ST_DEALER_EVAL : ST_PLAYER_WAIT;
                    else
                        req_d = 1'b1;
                end
            end
            ST_PLAYER_WAIT: begin
                if (i_ready && (i_command == COMMAND_HIT)) begin
                    req_d   = 1'b1;
                    state_d = ST_PLAYER_DRAW;
                end else if (i_ready && (i_command == COMMAND_STAND)) begin
                    state_d = ST_DEALER_EVAL;
                end
            end
            ST_PLAYER_DRAW: begin
                if (accept) begin
                    req_d = 1'b0;
                end else if (!req_q) begin
                    if (p_bust)
                        state_d = ST_RESOLVE;
                    else if (p_best == SUM_W'(21))
                        state_d = ST_DEALER_EVAL;
                    else
                        state_d = ST_PLAYER_WAIT;
                end
            end
            ST_DEALER_EVAL: begin
                if ((d_best < SUM_W'(DEALER_STAND)) || dealer_soft_hit) begin
                    req_d   = 1'b1;
                    state_d = ST_DEALER_DRAW;
                end else begin
                    state_d = ST_RESOLVE;
                end
            end
            ST_DEALER_DRAW: begin
                // The dealer total is updated by the time DEALER_EVAL looks at it.
                if (accept) begin
                    req_d   = 1'b0;
                    state_d = ST_DEALER_EVAL;
                end
            end
            ST_RESOLVE: begin
                if (p_bust)
                    result_d = RESULT_DEALER_WIN;
                else if (d_bust)
                    result_d = RESULT_PLAYER_WIN;
                else if (p_best > d_best)
                    result_d = RESULT_PLAYER_WIN;
                else if (d_best > p_best)
                    result_d = RESULT_DEALER_WIN;
                else
                    result_d = RESULT_PUSH;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            result_q <= RESULT_NONE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            result_q <= result_d;
        end
    end

    // Destination of the card currently being requested.
    always_comb begin
        o_cardToDealer = 1'b0;
        if (state_q == ST_DEAL)
            o_cardToDealer = cnt_q[0];
        else if (state_q == ST_DEALER_DRAW)
            o_cardToDealer = 1'b1;
    end

    assign o_cardReq       = req_q;
    assign o_turnIndicator = (state_q == ST_PLAYER_WAIT);
    assign o_playerSum     = p_best;
    assign o_dealerSum     = d_best;
    assign o_result        = result_q;
    assign o_busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_blackjack_turn_controller.sv
// Bench for blackjack_turn_controller: directed hand table, randomized hands
// against a rule-level game model, plus stall / async-reset sequences.
module tb_blackjack_turn_controller;
    import blackjack_turn_controller_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_dealButtonPushed = 1'b0;
    logic       i_ready = 1'b0;
    logic [1:0] i_command = 2'd0;
    logic       i_cardValid = 1'b0;
    logic [3:0] i_cardValue = 4'd0;
    logic       o_cardReq, o_cardToDealer, o_turnIndicator, o_busy;
    logic [4:0] o_playerSum, o_dealerSum;
    logic [1:0] o_result;

    blackjack_turn_controller dut (
        .i_clk              (i_clk),
        .i_reset_n          (i_reset_n),
        .i_dealButtonPushed (i_dealButtonPushed),
        .i_ready            (i_ready),
        .i_command          (i_command),
        .i_cardValid        (i_cardValid),
        .i_cardValue        (i_cardValue),
        .o_cardReq          (o_cardReq),
        .o_cardToDealer     (o_cardToDealer),
        .o_turnIndicator    (o_turnIndicator),
        .o_playerSum        (o_playerSum),
        .o_dealerSum        (o_dealerSum),
        .o_result           (o_result),
        .o_busy             (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- rule-level game model ----------------
    int cards[32];
    int exp_dest[32];
    int exp_p, exp_d, exp_res, exp_hits, exp_turns, exp_ncards, exp_deal_pbest;

    function automatic int clampv(input int v);
        return (v == 0 || v > 10) ? 10 : v;
    endfunction

    function automatic int bestv(input int h, input bit a);
        return (a && h <= 11) ? h + 10 : h;
    endfunction

    function automatic int addsat(input int h, input int v);
        return (h + v > 31) ? 31 : h + v;
    endfunction

    function automatic bit dealer_wants(input int h, input bit a);
        bit w;
        w = bestv(h, a) < 17;
`ifdef DEALER_HIT_SOFT17_EN
        if (bestv(h, a) == 17 && a && h <= 11) w = 1'b1;
`endif
        return w;
    endfunction

    // Player hits while best < thr (unless dealt 21 or already at 21/bust).
    task automatic model_game(input int thr);
        int ph, dh, n, v, pb, db;
        bit pa, da, going;
        ph = 0; dh = 0; pa = 0; da = 0;
        for (int i = 0; i < 4; i++) begin
            v = clampv(cards[i]);
            if (i % 2 == 0) begin ph = addsat(ph, v); pa = pa | (v == 1); exp_dest[i] = 0; end
            else            begin dh = addsat(dh, v); da = da | (v == 1); exp_dest[i] = 1; end
        end
        n = 4;
        exp_deal_pbest = bestv(ph, pa);
        exp_hits = 0; exp_turns = 0;
        if (bestv(ph, pa) != 21) begin
            going = 1;
            while (going) begin
                exp_turns++;
                if (bestv(ph, pa) < thr) begin
                    exp_hits++;
                    v = clampv(cards[n % 32]); exp_dest[n % 32] = 0; n++;
                    ph = addsat(ph, v); pa = pa | (v == 1);
                    if (ph > 21 || bestv(ph, pa) == 21) going = 0;
                end else going = 0;
            end
        end
        if (ph <= 21) begin
            while (dealer_wants(dh, da)) begin
                v = clampv(cards[n % 32]); exp_dest[n % 32] = 1; n++;
                dh = addsat(dh, v); da = da | (v == 1);
            end
        end
        pb = bestv(ph, pa); db = bestv(dh, da);
        if (ph > 21)       exp_res = int'(RESULT_DEALER_WIN);
        else if (dh > 21)  exp_res = int'(RESULT_PLAYER_WIN);
        else if (pb > db)  exp_res = int'(RESULT_PLAYER_WIN);
        else if (db > pb)  exp_res = int'(RESULT_DEALER_WIN);
        else               exp_res = int'(RESULT_PUSH);
        exp_ncards = n; exp_p = pb; exp_d = db;
    endtask

    // ---------------- game driver (called at a negedge, DUT idle/done) -------
    task automatic run_game(input int ep, input int ed, input int er, input int eturns);
        int ncard, hits, turns, cyc;
        bit hit_pend, idle_pend, first, done;
        ncard = 0; hits = 0; turns = 0; cyc = 0;
        hit_pend = 0; idle_pend = 0; first = 1; done = 0;
        i_dealButtonPushed = 1'b1;
        @(negedge i_clk);
        i_dealButtonPushed = 1'b0;
        chk("new_hand_result_none", o_result, int'(RESULT_NONE));
        chk("new_hand_req", o_cardReq, 1);
        while (!done && cyc < 2000) begin
            i_cardValid = 1'b0; i_ready = 1'b0; i_command = COMMAND_NONE; i_dealButtonPushed = 1'b0;
            if (hit_pend) begin chk("hit_req_latency", o_cardReq, 1); hit_pend = 0; end
            if (idle_pend) begin chk("wait_hold", o_turnIndicator, 1); idle_pend = 0; end
            if (!o_busy) done = 1;
            else if (o_cardReq) begin
                chk("card_dest", o_cardToDealer, exp_dest[ncard % 32]);
                if ($urandom_range(2) != 0) begin
                    i_cardValid = 1'b1; i_cardValue = 4'(cards[ncard % 32]); ncard++;
                end
            end else begin
                if ($urandom_range(3) == 0) begin
                    i_cardValid = 1'b1; i_cardValue = 4'($urandom_range(15));
                end
                if (o_turnIndicator) begin
                    if (first) begin chk("deal_player_sum", o_playerSum, exp_deal_pbest); first = 0; end
                    if ($urandom_range(3) == 0) begin
                        idle_pend = 1;
                        if ($urandom_range(1) == 1) i_dealButtonPushed = 1'b1;
                        else begin i_ready = 1'b1; i_command = COMMAND_NONE; end
                    end else begin
                        turns++; i_ready = 1'b1;
                        if (hits < exp_hits) begin i_command = COMMAND_HIT; hits++; hit_pend = 1; end
                        else i_command = COMMAND_STAND;
                    end
                end
            end
            if (!done) begin @(negedge i_clk); cyc++; end
        end
        if (!done) chk("game_timeout", cyc, -1);
        chk("cards_used", ncard, exp_ncards);
        chk("player_turns", turns, eturns);
        chk("player_sum", o_playerSum, ep);
        chk("dealer_sum", o_dealerSum, ed);
        chk("result", o_result, er);
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        logic [31:0] c;     // card i in nibble i
        int thr;
        int ep;
        int ed;
        int er;
        int eturns;
    } vec_t;

    function automatic logic [31:0] pack8(input int a, b, c, d, e, f, g, h);
        return {4'(h), 4'(g), 4'(f), 4'(e), 4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    vec_t vecs[6];

    task automatic load_vec(input vec_t v);
        logic [31:0] cc;
        cc = v.c;
        for (int i = 0; i < 32; i++) cards[i] = (i < 8) ? int'(cc[i*4 +: 4]) : 2;
    endtask

    initial begin
        vecs[0] = '{pack8(10, 7, 9, 10, 2, 2, 2, 2), 0, 19, 17, int'(RESULT_PLAYER_WIN), 1};
        vecs[1] = '{pack8(1, 5, 10, 6, 10, 2, 2, 2), 0, 21, 21, int'(RESULT_PUSH), 0};
        vecs[2] = '{pack8(10, 10, 6, 7, 8, 2, 2, 2), 17, 24, 17, int'(RESULT_DEALER_WIN), 1};
`ifdef DEALER_HIT_SOFT17_EN
        vecs[3] = '{pack8(9, 1, 8, 6, 3, 2, 2, 2), 0, 17, 20, int'(RESULT_DEALER_WIN), 1};
`else
        vecs[3] = '{pack8(9, 1, 8, 6, 3, 2, 2, 2), 0, 17, 17, int'(RESULT_PUSH), 1};
`endif
        vecs[4] = '{pack8(0, 15, 11, 2, 9, 2, 2, 2), 0, 20, 21, int'(RESULT_DEALER_WIN), 1};
        vecs[5] = '{pack8(1, 10, 5, 7, 3, 2, 2, 2), 18, 19, 17, int'(RESULT_PLAYER_WIN), 2};

        // Reset state.
        repeat (2) @(negedge i_clk);
        chk("reset_outputs", int'({o_cardReq, o_cardToDealer, o_turnIndicator, o_busy,
                                    o_result, o_playerSum, o_dealerSum}), 0);
        i_reset_n = 1'b1;
        @(negedge i_clk);

        for (int k = 0; k < 6; k++) begin
            load_vec(vecs[k]);
            model_game(vecs[k].thr);
            run_game(vecs[k].ep, vecs[k].ed, vecs[k].er, vecs[k].eturns);
        end

        for (int g = 0; g < 20; g++) begin
            int thr;
            for (int i = 0; i < 32; i++) cards[i] = $urandom_range(15);
            thr = $urandom_range(21, 12);
            model_game(thr);
            run_game(exp_p, exp_d, exp_res, exp_turns);
        end

        // Stall during the deal after two cards, then abort with async reset.
        begin
            int got, cyc;
            got = 0; cyc = 0;
            i_dealButtonPushed = 1'b1;
            @(negedge i_clk);
            i_dealButtonPushed = 1'b0;
            while (got < 2 && cyc < 20) begin
                i_cardValid = 1'b0;
                if (o_cardReq) begin
                    i_cardValid = 1'b1; i_cardValue = (got == 0) ? 4'd7 : 4'd3; got++;
                end
                @(negedge i_clk); cyc++;
            end
            i_cardValid = 1'b0;
            chk("stall_cards_given", got, 2);
            for (int s = 0; s < 50; s++) begin
                @(negedge i_clk);
                chk("stall_req_busy_noturn", int'({o_cardReq, o_busy, o_turnIndicator}), 3'b110);
            end
            chk("stall_player_sum", o_playerSum, 7);
            chk("stall_dealer_sum", o_dealerSum, 3);
            #2 i_reset_n = 1'b0;
            #1;
            chk("async_reset_req", o_cardReq, 0);
            chk("async_reset_outputs", int'({o_cardReq, o_cardToDealer, o_turnIndicator, o_busy,
                                              o_result, o_playerSum, o_dealerSum}), 0);
            @(negedge i_clk);
            i_reset_n = 1'b1;
            @(negedge i_clk);
        end

        // Fresh hand from IDLE after the abort.
        load_vec(vecs[0]);
        model_game(vecs[0].thr);
        run_game(vecs[0].ep, vecs[0].ed, vecs[0].er, vecs[0].eturns);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
